multi_turn_timer: RTL and testbench



---
 rtl/chess_pkg.sv | 19 +
 rtl/btn_edge_arb.sv | 49 ++++
 rtl/multi_turn_timer.sv | 162 ++++++++++++++++
 tb/tb_multi_turn_timer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared types and default timing constants for the chess-clock datapath.
// Used by the turn timer and the setup menu block.
package chess_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        TIMEOUT
    } state_t;

    localparam int DEF_CNT_W       = 9;
    localparam int DEF_LIMIT_SHORT = 100;
    localparam int DEF_LIMIT_LONG  = 300;
    localparam int DEF_WARN_LEAD   = 50;
    localparam int DEF_WARN_LEN    = 2;
    localparam int DEF_FLASH_BIT   = 1;

endpackage

// File: rtl/btn_edge_arb.sv
// Rising-edge detector and lowest-index arbiter for a bank of buttons.
// Emits a registered single-cycle event plus the winning index.
module btn_edge_arb #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  btn,
    output logic          ev_valid,
    output logic [IW-1:0] ev_idx
);

    logic [N-1:0]  btn_q;
    logic          armed;
    logic [N-1:0]  rise;
    logic          hit;
    logic [IW-1:0] idx;

    // Edges are masked on the first clock after reset so that a button
    // held through reset loads the history without firing.
    always_comb begin
        rise = btn & ~btn_q & {N{armed}};
        hit  = 1'b0;
        idx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rise[i]) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

    // Button history and registered event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q    <= '0;
            armed    <= 1'b0;
            ev_valid <= 1'b0;
            ev_idx   <= '0;
        end else begin
            btn_q    <= btn;
            armed    <= 1'b1;
            ev_valid <= hit;
            ev_idx   <= idx;
        end
    end

endmodule

// File: rtl/multi_turn_timer.sv
// N-player turn timer: counts ticks for the active player, flashes a
// warning, then latches buzzer/display timeout and a history bit.
module multi_turn_timer
    import chess_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int PW          = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LIMIT_SHORT = DEF_LIMIT_SHORT,
    parameter int LIMIT_LONG  = DEF_LIMIT_LONG,
    parameter int WARN_LEAD   = DEF_WARN_LEAD,
    parameter int WARN_LEN    = DEF_WARN_LEN,
    parameter int FLASH_BIT   = DEF_FLASH_BIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic [NUM_PLAYERS-1:0] btn,
    input  logic                   scale,
    input  logic                   pause,
    output logic [PW-1:0]          active,
    output logic [NUM_PLAYERS-1:0] active_oh,
    output logic [CNT_W-1:0]       cnt_dis,
    output logic                   led,
    output logic                   buzz_en,
    output logic                   seg_en,
    output logic [NUM_PLAYERS-1:0] timed_out
);

    if (NUM_PLAYERS < 2 || NUM_PLAYERS > 8) begin : g_bad_np
        $error("NUM_PLAYERS must be 2..8");
    end
    if (LIMIT_LONG >= (1 << CNT_W)) begin : g_bad_long
        $error("LIMIT_LONG does not fit in CNT_W bits");
    end
    if (WARN_LEAD + WARN_LEN > LIMIT_SHORT) begin : g_bad_warn
        $error("warning window exceeds LIMIT_SHORT");
    end

    localparam logic [CNT_W-1:0] L_SHORT = CNT_W'(LIMIT_SHORT);
    localparam logic [CNT_W-1:0] L_LONG  = CNT_W'(LIMIT_LONG);
    localparam logic [CNT_W-1:0] W_LEAD  = CNT_W'(WARN_LEAD);
    localparam logic [CNT_W-1:0] W_LEN   = CNT_W'(WARN_LEN);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]            active_q, active_d;
    logic                     scale_q, scale_d;
    logic                     led_en_q, led_en_d;
    logic                     buzz_q, buzz_d;
    logic                     seg_q, seg_d;
    logic [NUM_PLAYERS-1:0]   to_q, to_d;

    logic                     ev_valid;
    logic [PW-1:0]            ev_idx;
    logic [CNT_W-1:0]         lim, warn_on, warn_off, cnt_inc;

    btn_edge_arb #(
        .N  (NUM_PLAYERS),
        .IW (PW)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .ev_valid (ev_valid),
        .ev_idx   (ev_idx)
    );

    // Limit follows the scale latched at turn start, not the live input.
    always_comb begin
        lim      = scale_q ? L_LONG : L_SHORT;
        warn_on  = lim - W_LEAD;
        warn_off = warn_on + W_LEN;
        cnt_inc  = cnt_q + CNT_W'(1);
    end

    // Next-state logic; a button event overrides tick and pause.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        scale_d  = scale_q;
        led_en_d = led_en_q;
        buzz_d   = buzz_q;
        seg_d    = seg_q;
        to_d     = to_q;
        if (ev_valid) begin
            state_d  = RUN;
            cnt_d    = '0;
            active_d = ev_idx;
            scale_d  = scale;
            led_en_d = 1'b0;
            buzz_d   = 1'b0;
            seg_d    = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (tick) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == warn_on)
                            led_en_d = 1'b1;
                        if (cnt_inc == warn_off)
                            led_en_d = 1'b0;
                        if (cnt_inc == lim) begin
                            led_en_d       = 1'b1;
                            buzz_d         = 1'b1;
                            seg_d          = 1'b1;
                            to_d[active_q] = 1'b1;
                            state_d        = TIMEOUT;
                        end
                    end
                end
                PAUSED: begin
                    if (!pause)
                        state_d = RUN;
                end
                IDLE, TIMEOUT: begin
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            active_q <= '0;
            scale_q  <= 1'b0;
            led_en_q <= 1'b0;
            buzz_q   <= 1'b0;
            seg_q    <= 1'b0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            scale_q  <= scale_d;
            led_en_q <= led_en_d;
            buzz_q   <= buzz_d;
            seg_q    <= seg_d;
            to_q     <= to_d;
        end
    end

    // One-hot view of the active player, blank while idle.
    always_comb begin
        active_oh = '0;
        if (state_q != IDLE)
            active_oh[active_q] = 1'b1;
    end

    assign active    = active_q;
    assign cnt_dis   = cnt_q;
    assign led       = led_en_q & cnt_q[FLASH_BIT];
    assign buzz_en   = buzz_q;
    assign seg_en    = seg_q;
    assign timed_out = to_q;

endmodule

// File: tb/tb_multi_turn_timer.sv
// Directed bench for the four-player turn timer.
// Expected values are hand-computed from the timer behaviour.
module tb_multi_turn_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] btn;
    logic       scale;
    logic       pause;
    logic [1:0] active;
    logic [3:0] active_oh;
    logic [8:0] cnt_dis;
    logic       led;
    logic       buzz_en;
    logic       seg_en;
    logic [3:0] timed_out;

    int n_pass = 0;
    int n_fail = 0;
    int n_tot  = 0;

    multi_turn_timer #(.NUM_PLAYERS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .btn       (btn),
        .scale     (scale),
        .pause     (pause),
        .active    (active),
        .active_oh (active_oh),
        .cnt_dis   (cnt_dis),
        .led       (led),
        .buzz_en   (buzz_en),
        .seg_en    (seg_en),
        .timed_out (timed_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            cyc();
        end
        tick = 1'b0;
    endtask

    task automatic press(input logic [3:0] m);
        btn = btn | m;
        cyc();
        cyc();
        btn = btn & ~m;
        cyc();
    endtask

    initial begin
        rst   = 1'b1;
        tick  = 1'b0;
        btn   = 4'b0010;
        scale = 1'b0;
        pause = 1'b0;
        repeat (3) cyc();
        check("rst_active_oh", active_oh, 0);
        check("rst_active", active, 0);
        check("rst_cnt", cnt_dis, 0);
        check("rst_led", led, 0);
        check("rst_buzz", buzz_en, 0);
        check("rst_seg", seg_en, 0);
        check("rst_timed_out", timed_out, 0);

        rst = 1'b0;
        repeat (3) cyc();
        check("held_no_event", active_oh, 0);
        btn[1] = 1'b0;
        cyc();
        btn[1] = 1'b1;
        cyc();
        check("press_lat1", active_oh, 0);
        cyc();
        check("press_active", active, 1);
        check("press_oh", active_oh, 4'b0010);
        check("press_cnt", cnt_dis, 0);
        btn[1] = 1'b0;
        cyc();

        scale = 1'b0;
        press(4'b0001);
        check("s_active", active, 0);
        ticks(49);
        check("s_cnt49", cnt_dis, 49);
        check("s_led49", led, 0);
        ticks(1);
        check("s_led50", led, 1);
        ticks(1);
        check("s_led51", led, 1);
        ticks(1);
        check("s_led52", led, 0);
        ticks(47);
        check("s_buzz99", buzz_en, 0);
        ticks(1);
        check("s_cnt100", cnt_dis, 100);
        check("s_buzz100", buzz_en, 1);
        check("s_seg100", seg_en, 1);
        check("s_to100", timed_out, 4'b0001);
        check("s_led100", led, 0);
        ticks(20);
        check("s_sat", cnt_dis, 100);
        check("s_buzz_hold", buzz_en, 1);

        scale = 1'b1;
        press(4'b0001);
        check("l_clr_buzz", buzz_en, 0);
        ticks(10);
        scale = 1'b0;
        ticks(90);
        check("l_cnt100", cnt_dis, 100);
        check("l_no_to100", buzz_en, 0);
        ticks(149);
        check("l_led249", led, 0);
        ticks(1);
        check("l_led250", led, 1);
        ticks(1);
        check("l_led251", led, 1);
        ticks(1);
        check("l_led252", led, 0);
        ticks(47);
        check("l_buzz299", buzz_en, 0);
        ticks(1);
        check("l_cnt300", cnt_dis, 300);
        check("l_buzz300", buzz_en, 1);
        check("l_seg300", seg_en, 1);

        press(4'b0001);
        ticks(40);
        check("p_cnt40", cnt_dis, 40);
        pause = 1'b1;
        ticks(30);
        check("p_hold", cnt_dis, 40);
        pause = 1'b0;
        cyc();
        ticks(59);
        check("p_cnt99", cnt_dis, 99);
        check("p_buzz99", buzz_en, 0);
        ticks(1);
        check("p_buzz100", buzz_en, 1);
        check("p_cnt100", cnt_dis, 100);

        press(4'b0011);
        check("sim_active", active, 0);
        check("sim_oh", active_oh, 4'b0001);
        check("sim_cnt", cnt_dis, 0);
        ticks(100);
        check("sim_to", buzz_en, 1);
        press(4'b0100);
        check("b2_active", active, 2);
        check("b2_buzz", buzz_en, 0);
        check("b2_seg", seg_en, 0);
        check("b2_to_keep", timed_out, 4'b0001);
        ticks(100);
        check("b2_to", timed_out, 4'b0101);

        tick = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ar_buzz", buzz_en, 0);
        check("ar_seg", seg_en, 0);
        check("ar_to", timed_out, 0);
        check("ar_oh", active_oh, 0);
        check("ar_cnt", cnt_dis, 0);
        check("ar_led", led, 0);
        tick = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
